// File: rtl/dom_ssaes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dom_ssaes_pkg
// Description : Shared constants and types for the DOM masking front end:
//               share width, LFSR taps and default seed, randomness-pool
//               bit-field offsets and the feeder FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dom_ssaes_pkg;

    localparam int SHARE_W = 2;
    localparam int LFSR_W  = 16;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (left-shift form)
    localparam int LFSR_TAP_0 = 15;
    localparam int LFSR_TAP_1 = 13;
    localparam int LFSR_TAP_2 = 12;
    localparam int LFSR_TAP_3 = 10;

    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    // Where each share field sits inside the 10-bit randomness pool
    localparam int POOL_AX_LSB = 0;
    localparam int POOL_AY_LSB = 2;
    localparam int POOL_BX_LSB = 4;
    localparam int POOL_BY_LSB = 6;
    localparam int POOL_Z_LSB  = 8;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Fibonacci LFSR, left shift, serial output on bit 15.
//               A zero seed would lock the register, so it is replaced by
//               SEED_DEFAULT on load.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               en             - advance one step
//               load, seed     - load new state (priority over en)
//               bit_out        - current MSB (the bit consumed this cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 #(
    parameter logic [15:0] SEED_DEFAULT = dom_ssaes_pkg::SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] seed,
    output logic        bit_out
);
    import dom_ssaes_pkg::*;

    logic [LFSR_W-1:0] r_state;
    logic              w_fb;

    assign w_fb = r_state[LFSR_TAP_0] ^ r_state[LFSR_TAP_1]
                ^ r_state[LFSR_TAP_2] ^ r_state[LFSR_TAP_3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED_DEFAULT;
        end else if (load) begin
            r_state <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
        end else if (en) begin
            r_state <= {r_state[LFSR_W-2:0], w_fb};
        end
    end

    assign bit_out = r_state[LFSR_W-1];

endmodule
`default_nettype wire

// File: rtl/dep_share_feeder.sv
`default_nettype none
// ============================================================================
// Module      : dep_share_feeder
// Description : Splits an unmasked GF(2^2) operand pair into three Boolean
//               shares each and supplies the fresh 2-bit randomness Z for
//               DepMultiplier. Ten fresh LFSR bits are collected per
//               transaction (FILL), then the stage waits for an operand pair
//               (ARMED) and holds the bundle until the consumer takes it.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               seed_load, seed          - reseed the LFSR, restart FILL
//               in_valid/in_ready        - operand handshake, a_in/b_in
//               out_valid/out_ready      - bundle handshake
//               Ax,Ay,Az,Bx,By,Bz,Z      - registered share bundle
// Revision    : 1.0 - initial release
// ============================================================================
module dep_share_feeder #(
    parameter logic [15:0] SEED_DEFAULT = dom_ssaes_pkg::SEED_DEFAULT,
    parameter int          RAND_BITS    = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               seed_load,
    input  logic [15:0]                        seed,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [dom_ssaes_pkg::SHARE_W-1:0]  a_in,
    input  logic [dom_ssaes_pkg::SHARE_W-1:0]  b_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [dom_ssaes_pkg::SHARE_W-1:0]  Ax,
    output logic [dom_ssaes_pkg::SHARE_W-1:0]  Ay,
    output logic [dom_ssaes_pkg::SHARE_W-1:0]  Az,
    output logic [dom_ssaes_pkg::SHARE_W-1:0]  Bx,
    output logic [dom_ssaes_pkg::SHARE_W-1:0]  By,
    output logic [dom_ssaes_pkg::SHARE_W-1:0]  Bz,
    output logic [dom_ssaes_pkg::SHARE_W-1:0]  Z
);
    import dom_ssaes_pkg::*;

    localparam logic [3:0] C_CNT_LAST = 4'(RAND_BITS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [RAND_BITS-1:0]   r_pool;
    logic [3:0]             r_cnt;
    logic                   w_fill;
    logic                   w_accept;
    logic                   w_lfsr_bit;

    logic [SHARE_W-1:0]     w_ax;
    logic [SHARE_W-1:0]     w_ay;
    logic [SHARE_W-1:0]     w_bx;
    logic [SHARE_W-1:0]     w_by;
    logic [SHARE_W-1:0]     w_z;

    lfsr16 #(
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en      (w_fill),
        .load    (seed_load),
        .seed    (seed),
        .bit_out (w_lfsr_bit)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake decode. A reseed overrides everything,
    // including a transaction offered in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_fill      = 1'b0;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        if (seed_load) begin
            w_state_nxt = FILL;
        end else begin
            case (r_state)
                FILL: begin
                    w_fill = 1'b1;
                    if (r_cnt == C_CNT_LAST) begin
                        w_state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    // Slot is free, or is being drained this very cycle
                    in_ready = !out_valid || out_ready;
                    w_accept = in_valid && in_ready;
                    if (w_accept) begin
                        w_state_nxt = FILL;
                    end
                end
                default: begin
                    w_state_nxt = FILL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Randomness pool: newest bit enters at bit 0, so the first bit drawn
    // after a refill ends up in the MSB.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pool <= '0;
            r_cnt  <= 4'd0;
        end else if (seed_load) begin
            r_pool <= '0;
            r_cnt  <= 4'd0;
        end else if (w_fill) begin
            r_pool <= {r_pool[RAND_BITS-2:0], w_lfsr_bit};
            r_cnt  <= r_cnt + 4'd1;
        end else if (w_accept) begin
            r_cnt  <= 4'd0;
        end
    end

    assign w_ax = r_pool[POOL_AX_LSB +: SHARE_W];
    assign w_ay = r_pool[POOL_AY_LSB +: SHARE_W];
    assign w_bx = r_pool[POOL_BX_LSB +: SHARE_W];
    assign w_by = r_pool[POOL_BY_LSB +: SHARE_W];
    assign w_z  = r_pool[POOL_Z_LSB  +: SHARE_W];

    // ------------------------------------------------------------------
    // Output slot: only shares are registered, never the plain operands.
    // Seed loads leave the slot alone.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Ax        <= '0;
            Ay        <= '0;
            Az        <= '0;
            Bx        <= '0;
            By        <= '0;
            Bz        <= '0;
            Z         <= '0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            Ax        <= w_ax;
            Ay        <= w_ay;
            Az        <= a_in ^ w_ax ^ w_ay;
            Bx        <= w_bx;
            By        <= w_by;
            Bz        <= b_in ^ w_bx ^ w_by;
            Z         <= w_z;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/dep_share_feeder.md
# dep_share_feeder

Upstream masking stage for `DepMultiplier`. It accepts one unmasked GF(2^2) operand pair (a, b) per transaction and splits each operand into three Boolean shares (x, y, z). It also supplies the fresh 2-bit randomness Z, then holds the result on registered outputs until the consumer takes it. Randomness comes from an internal 16-bit LFSR; every transaction uses 10 bits that no other transaction has used.

## Interface
Parameters:
- `SEED_DEFAULT`, 16'hACE1: LFSR value after reset, and the substitute used when a zero seed is loaded.
- `RAND_BITS`, 10: pool bits consumed per transaction. Fixed at 4 shares × 2 bits + 2 bits of Z.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `seed_load`  in  1: reseed strobe.
- `seed`  in  16: new LFSR state. A value of 0 is replaced by `SEED_DEFAULT`.
- `in_valid`  in  1: the a/b pair is valid.
- `in_ready`  out  1: the stage accepts a pair this cycle.
- `a_in`, `b_in`  in  2 each: unmasked operands.
- `out_valid`  out  1: the share bundle is valid.
- `out_ready`  in  1: the consumer takes the bundle.
- `Ax`, `Ay`, `Az`, `Bx`, `By`, `Bz`, `Z`  out  2 each: share bundle; connects 1:1 to `DepMultiplier`.

## Operation
- LFSR: Fibonacci, left shift.
  - Feedback: `fb = l[15]^l[13]^l[12]^l[10]`.
  - Update: `l <= {l[14:0], fb}`.
  - The output bit is `l[15]`.
  - The LFSR advances only in state FILL.
- Pool: 10-bit register, `pool <= {pool[8:0], l[15]}` on each FILL cycle. The 4-bit counter `cnt` counts FILL cycles.
- FSM:
  - FILL: shift the LFSR and the pool, `cnt++`. When `cnt==9` (the 10th bit is being shifted in), go to ARMED. `in_ready=0`.
  - ARMED: `in_ready = !out_valid || out_ready`. On accept (`in_valid && in_ready`), load the output registers, set `out_valid=1`, clear `cnt`, and go to FILL. With no accept, stay in ARMED and freeze the pool.
- Share mapping at accept:
  - `Ax=pool[1:0]`, `Ay=pool[3:2]`, `Bx=pool[5:4]`, `By=pool[7:6]`, `Z=pool[9:8]`.
  - `Az=a_in^Ax^Ay`, `Bz=b_in^Bx^By`.
- Output slot:
  - `out_valid` falls on `out_ready` unless a new accept happens in the same cycle; an accept re-asserts it with the new data.
  - The share outputs change only on accept.
- Seed load:
  - Load the LFSR with `seed` (or `SEED_DEFAULT` if `seed==0`), clear `pool` and `cnt`, and go to FILL.
  - The output slot (`out_valid` and data) is untouched.
  - A transaction offered in the same cycle is not accepted: `in_ready` is forced to 0.
- Reset, including mid-transaction:
  - LFSR = `SEED_DEFAULT`, `pool=0`, `cnt=0`, state FILL.
  - `out_valid=0`, all share outputs 0, `in_ready=0`.
  - Reset has priority over `seed_load`.
- GF(2^2) values are treated as plain 2-bit vectors; no field arithmetic happens here. Unmasked a/b are never registered; only shares are.

## Timing
- First `in_ready` is 10 cycles after reset deasserts (cycles 0..9 in FILL, ARMED at cycle 10).
- Latency: accept at edge t → bundle valid with `out_valid=1` after edge t, i.e. in cycle t+1.
- Throughput: at most one accept per 11 cycles.
- Backpressure stalls only the ARMED state. FILL proceeds regardless of `out_ready`.
- `in_ready` does not depend on `in_valid`. It depends combinationally on `out_ready`.

## Structure
- Shared package `dom_ssaes_pkg`:
  - `SHARE_W=2`
  - LFSR tap constants
  - `SEED_DEFAULT`
  - FSM state enum {FILL, ARMED}
  - pool bit-field offsets
- One sub-module, `lfsr16`: handles enable, load, zero-seed substitution, and the `l[15]` output. The FSM, pool, and output slot stay in `dep_share_feeder`.

## Test plan
1. Reset release, `in_valid=1` constantly → `in_ready=0` for cycles 0–9 and `1` at cycle 10. The pool is 10'b1010110011 (top 10 bits of 0xACE1).
2. Accept at cycle 10 with a=2, b=3 → next cycle: Ax=3, Ay=0, Az=1, Bx=3, By=2, Bz=2, Z=2. Check `Ax^Ay^Az==2` and `Bx^By^Bz==3`.
3. Hold `out_ready=0` after accept → `out_valid` and the bundle stay stable. The next ARMED state shows `in_ready=0` until `out_ready=1`. Then the accept and drain happen in the same cycle and `out_valid` stays 1 with the new data.
4. `seed_load` with `seed=0` in ARMED → `in_ready` drops, then 10 FILL cycles. The next pool equals the top 10 bits of 0xACE1 again, and the prior bundle is unchanged.
5. Assert `rst` for 1 cycle at FILL `cnt=5` with `out_valid=1` → all outputs 0, `out_valid=0`, and the first `in_ready` comes 10 cycles later.
6. 1000 random transactions → shares always XOR to the inputs, and no pool value is reused across consecutive transactions.
